// File: rtl/game_pkg.sv
// Shared encodings for the game-logic datapath: round states, sprite indices,
// movement directions and the sprite reset positions reloaded at round start.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DYING = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  localparam int NUM_SPRITES = 5;
  localparam int PACMAN      = 0;
  localparam int BLINKY      = 1;
  localparam int PINKY       = 2;
  localparam int INKY        = 3;
  localparam int CLYDE       = 4;

  typedef enum logic [3:0] {
    DIR_RIGHT = 4'b0001,
    DIR_UP    = 4'b0010,
    DIR_DOWN  = 4'b0100,
    DIR_LEFT  = 4'b1000
  } dir_e;

  // Reset positions in maze tile coordinates, consumed by the sprite movers.
  localparam logic [7:0] PACMAN_RST_X = 8'd13;
  localparam logic [7:0] PACMAN_RST_Y = 8'd26;
  localparam logic [7:0] BLINKY_RST_X = 8'd13;
  localparam logic [7:0] BLINKY_RST_Y = 8'd14;
  localparam logic [7:0] PINKY_RST_X  = 8'd13;
  localparam logic [7:0] PINKY_RST_Y  = 8'd17;
  localparam logic [7:0] INKY_RST_X   = 8'd11;
  localparam logic [7:0] INKY_RST_Y   = 8'd17;
  localparam logic [7:0] CLYDE_RST_X  = 8'd15;
  localparam logic [7:0] CLYDE_RST_Y  = 8'd17;

  localparam dir_e PACMAN_RST_DIR = DIR_LEFT;
  localparam dir_e BLINKY_RST_DIR = DIR_LEFT;
  localparam dir_e PINKY_RST_DIR  = DIR_UP;
  localparam dir_e INKY_RST_DIR   = DIR_UP;
  localparam dir_e CLYDE_RST_DIR  = DIR_UP;

  // Isolates the lowest set bit (two's-complement trick); zero stays zero.
  function automatic logic [NUM_SPRITES-1:0] lowest_set(input logic [NUM_SPRITES-1:0] v);
    return v & (~v + {{(NUM_SPRITES-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/sprite_update_sequencer.sv
// Serialises sprite update requests into one-hot strobes, lowest index first.
// New requests merge into the pending mask; flush drops everything next cycle.
module sprite_update_sequencer
  import game_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SPRITES-1:0] req_i,
  input  logic                   flush_i,
  output logic [NUM_SPRITES-1:0] upd_en_o
);

  logic [NUM_SPRITES-1:0] pending_q, pending_d;
  logic [NUM_SPRITES-1:0] upd_q, upd_d;
  logic [NUM_SPRITES-1:0] merged;
  logic [NUM_SPRITES-1:0] grant;

  // Requests arriving this cycle are eligible immediately so a tick at
  // cycle N can strobe at N+1.
  always_comb begin
    merged    = pending_q | req_i;
    grant     = lowest_set(merged);
    pending_d = merged & ~grant;
    upd_d     = grant;
    if (flush_i) begin
      pending_d = '0;
      upd_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      upd_q     <= '0;
    end else begin
      pending_q <= pending_d;
      upd_q     <= upd_d;
    end
  end

  assign upd_en_o = upd_q;

endmodule

// File: rtl/game_flow_controller.sv
// Round sequencer: start/ready/play/death/game-over flow, lives, sprite reload
// pulse and per-frame sprite step scheduling at independent Pac-Man/ghost rates.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int READY_FRAMES = 120,
  parameter int DEATH_FRAMES = 90,
  parameter int PACMAN_DIV   = 2,
  parameter int GHOST_DIV    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pacman_is_dead,
  output logic [4:0] sprite_upd_en,
  output logic       sprite_reload,
  output logic [1:0] lives,
  output logic [2:0] game_state,
  output logic       freeze,
  output logic       game_over
);

  localparam int FRAME_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int FRAME_W   = $clog2(FRAME_MAX) + 1;
  localparam int PAC_W     = $clog2(PACMAN_DIV) + 1;
  localparam int GHOST_W   = $clog2(GHOST_DIV) + 1;

  localparam logic [FRAME_W-1:0] READY_LAST = FRAME_W'(READY_FRAMES - 1);
  localparam logic [FRAME_W-1:0] DEATH_LAST = FRAME_W'(DEATH_FRAMES - 1);
  localparam logic [PAC_W-1:0]   PAC_LAST   = PAC_W'(PACMAN_DIV - 1);
  localparam logic [GHOST_W-1:0] GHOST_LAST = GHOST_W'(GHOST_DIV - 1);
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);

  game_state_e            state_q, state_d;
  logic [1:0]             lives_q, lives_d;
  logic                   reload_q, reload_d;
  logic [FRAME_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [PAC_W-1:0]       pac_cnt_q, pac_cnt_d;
  logic [GHOST_W-1:0]     ghost_cnt_q, ghost_cnt_d;
  logic                   start_prev_q;
  logic                   start_edge;
  logic [NUM_SPRITES-1:0] step_req;
  logic                   flush;

  assign start_edge = start_btn & ~start_prev_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    reload_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    pac_cnt_d   = pac_cnt_q;
    ghost_cnt_d = ghost_cnt_q;
    step_req    = '0;
    flush       = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          lives_d     = LIVES_LOAD;
          reload_d    = 1'b1;
          frame_cnt_d = '0;
          state_d     = ST_READY;
        end
      end

      ST_READY: begin
        if (frame_tick) begin
          if (frame_cnt_q == READY_LAST) begin
            frame_cnt_d = '0;
            pac_cnt_d   = '0;
            ghost_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      // Death takes priority over a coincident frame tick: no step requests.
      ST_PLAY: begin
        if (pacman_is_dead) begin
          flush       = 1'b1;
          frame_cnt_d = '0;
          state_d     = ST_DYING;
          if (lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
        end else if (frame_tick) begin
          if (pac_cnt_q == PAC_LAST) begin
            pac_cnt_d        = '0;
            step_req[PACMAN] = 1'b1;
          end else begin
            pac_cnt_d = pac_cnt_q + 1'b1;
          end
          if (ghost_cnt_q == GHOST_LAST) begin
            ghost_cnt_d          = '0;
            step_req[CLYDE:BLINKY] = 4'hF;
          end else begin
            ghost_cnt_d = ghost_cnt_q + 1'b1;
          end
        end
      end

      ST_DYING: begin
        if (frame_tick) begin
          if (frame_cnt_q == DEATH_LAST) begin
            frame_cnt_d = '0;
            if (lives_q == 2'd0) begin
              state_d = ST_OVER;
            end else begin
              reload_d = 1'b1;
              state_d  = ST_READY;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      lives_q      <= '0;
      reload_q     <= 1'b0;
      frame_cnt_q  <= '0;
      pac_cnt_q    <= '0;
      ghost_cnt_q  <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      reload_q     <= reload_d;
      frame_cnt_q  <= frame_cnt_d;
      pac_cnt_q    <= pac_cnt_d;
      ghost_cnt_q  <= ghost_cnt_d;
      start_prev_q <= start_btn;
    end
  end

  sprite_update_sequencer u_seq (
    .clk      (clk),
    .rst_n    (rst),
    .req_i    (step_req),
    .flush_i  (flush),
    .upd_en_o (sprite_upd_en)
  );

  assign sprite_reload = reload_q;
  assign lives         = lives_q;
  assign game_state    = state_q;
  assign freeze        = (state_q != ST_PLAY);
  assign game_over     = (state_q == ST_OVER);

endmodule
